step_sequencer: RTL and testbench
=================================

Name: step_sequencer

Overview:
- Pattern step sequencer that drives the pitch-lookup/oscillator voice.
- Replaces the button-driven shift register as the source of scale_degree and gate.
- Holds a STEPS-entry pattern of scale degrees, writable at any time; while run is high it plays the pattern in a loop.
- Each step: gate is high for GATE_CLKS cycles, then low for the rest of the step.

Parameters:
- STEPS, 8, number of pattern entries; power of two, 2..16.
- STEP_CLKS, 524288, clk cycles per step (tempo).
- GATE_CLKS, 393216, clk cycles gate is high within a step; 1 <= GATE_CLKS <= STEP_CLKS.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- run  in  1  level; high = play, low = stop
- wr_en  in  1  pattern write strobe, one entry per cycle
- wr_addr  in  log2(STEPS)  pattern index to write
- wr_degree  in  4  scale degree to store; 0 = rest
- scale_degree  out  4  degree of the current step, to pitch lookup
- gate  out  1  note gate; AND with oscillator output
- step  out  log2(STEPS)  current step index (LEDs)
- step_strobe  out  1  one-cycle pulse on the first cycle of each step

Behaviour:
- Reset (rst high at a clk edge):
  - all pattern entries = 0; state IDLE.
  - scale_degree=0, gate=0, step=0, step_strobe=0; cycle counter=0.
  - Reset overrides run and wr_en in the same cycle.
  - Reset mid-step aborts immediately; gate is low the next cycle.
- States: IDLE, GATE_ON, GATE_OFF.
- IDLE:
  - outputs scale_degree=0, gate=0, step=0, step_strobe=0.
  - If run is sampled high at edge n, then at edge n+1: state=GATE_ON, step=0, step_strobe=1, scale_degree=pattern[0], gate=(pattern[0]!=0).
- Step start:
  - scale_degree is latched from the pattern and held constant for the whole step.
  - counter is cleared to 0 and increments every cycle.
- GATE_ON:
  - when counter==GATE_CLKS-1 and GATE_CLKS<STEP_CLKS, go to GATE_OFF; gate=0 from the next cycle; scale_degree is held.
- GATE_OFF / end of step:
  - when counter==STEP_CLKS-1, the next cycle starts step (step+1) mod STEPS (STEPS-1 wraps to 0).
  - state=GATE_ON, step_strobe=1, new degree and gate per the step-start rule.
- GATE_CLKS==STEP_CLKS: legato. GATE_OFF is never entered; gate stays high across consecutive non-rest steps.
- Rest step (degree 0): gate stays 0 for the whole step. Timing, step and step_strobe still advance normally.
- Stop: run sampled low in any play state returns to IDLE next cycle. Outputs take IDLE values and step returns to 0. The next start always begins at step 0.
- Writes:
  - wr_en high writes pattern[wr_addr]=wr_degree at the edge.
  - Writes are accepted in every state except reset.
- Write to the currently playing step: takes effect on the next visit; the held scale_degree is unchanged.
- Write colliding with a step-start read of the same address: the read returns the old value (read-before-write).
- step_strobe is never high for two consecutive cycles, except when STEP_CLKS==1.
- Counter width is clog2(STEP_CLKS). No arithmetic overflow is allowed; the counter is compared against STEP_CLKS-1 and never wraps naturally.

Decomposition:
- Shared package (seq_pkg):
  - state encoding (IDLE/GATE_ON/GATE_OFF);
  - DEGREE_W=4;
  - REST_DEGREE=0;
  - helper for step index width clog2(STEPS).
- One sub-module, step_timer: owns the cycle counter.
  - Inputs: clk, rst, clear.
  - Outputs: one-cycle pulses gate_end (counter==GATE_CLKS-1) and step_end (counter==STEP_CLKS-1).
  - The FSM and pattern storage stay in step_sequencer.

Test Plan:
Bench parameters for all scenarios: STEPS=4, STEP_CLKS=8, GATE_CLKS=6.
1. Reset + idle: rst for 2 cycles, run=0 for 20 cycles -> gate=0, scale_degree=0, step=0, step_strobe=0 throughout.
2. Basic loop:
   - stimulus: write pattern {3,0,5,7}, raise run.
   - step 0 starts 1 cycle later: scale_degree=3, gate high 6 cycles then low 2.
   - step 1: degree 0, gate low all 8 cycles.
   - steps 2, 3: degrees 5, 7.
   - after 32 cycles step wraps to 0; step_strobe every 8 cycles.
3. Mid-step write: during step 2, write addr 2 = 9 -> scale_degree stays 5 until step end; next loop plays 9 at step 2.
4. Collision: write addr 1 = 4 in the same cycle step 1 starts -> step 1 plays the old value 0 (gate low); the next loop plays 4.
5. Stop/restart: drop run in cycle 3 of step 2 -> next cycle gate=0, step=0, IDLE. Raise run again -> restarts at step 0 with step_strobe.
6. Legato + reset mid-step:
   - GATE_CLKS=8, pattern {2,2,2,2} -> gate continuously high across steps.
   - assert rst mid-step -> next cycle gate=0, pattern reads back all zero (rests) after restart.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the pattern step sequencer.
//   seq_state_e : play-state encoding (idle, gate high, gate low)
//   DEGREE_W    : width of a scale degree
//   REST_DEGREE : degree value that means "no note"
//   step_idx_w  : width of a step index for a given pattern length
package seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGateOn,
        StGateOff
    } seq_state_e;

    localparam int unsigned DEGREE_W = 4;
    localparam logic [DEGREE_W-1:0] REST_DEGREE = '0;

    function automatic int unsigned step_idx_w(input int unsigned steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Cycle counter for one sequencer step.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   clear    : hold the counter at 0 (idle or stopping)
//   gate_end : high while counter == GATE_CLKS-1
//   step_end : high while counter == STEP_CLKS-1
// The counter returns to 0 after STEP_CLKS-1, so each step starts at 0.
module step_timer #(
    parameter int unsigned STEP_CLKS = 524288,
    parameter int unsigned GATE_CLKS = 393216
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic gate_end,
    output logic step_end
);

    localparam int unsigned CNT_W = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CLKS - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CLKS - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear || step_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign gate_end = (cnt_q == GATE_LAST);
    assign step_end = (cnt_q == STEP_LAST);

endmodule

// File: rtl/step_sequencer.sv
// Pattern step sequencer feeding the pitch-lookup/oscillator voice.
//   clk, rst     : system clock, synchronous active-high reset
//   run          : high = play pattern in a loop, low = stop
//   wr_en        : write pattern[wr_addr] = wr_degree at the edge
//   wr_addr      : pattern index to write
//   wr_degree    : scale degree to store (0 = rest)
//   scale_degree : degree of the current step, held for the whole step
//   gate         : note gate, high for GATE_CLKS cycles of a non-rest step
//   step         : current step index
//   step_strobe  : one-cycle pulse on the first cycle of each step
module step_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned STEPS     = 8,
    parameter int unsigned STEP_CLKS = 524288,
    parameter int unsigned GATE_CLKS = 393216,
    localparam int unsigned IDX_W    = step_idx_w(STEPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [DEGREE_W-1:0] wr_degree,
    output logic [DEGREE_W-1:0] scale_degree,
    output logic                gate,
    output logic [IDX_W-1:0]    step,
    output logic                step_strobe
);

    // With legato timing the gate never drops inside a step.
    localparam bit HAS_GATE_OFF = (GATE_CLKS < STEP_CLKS);

    seq_state_e          state_q, state_d;
    logic [IDX_W-1:0]    step_q, step_d;
    logic [DEGREE_W-1:0] degree_q, degree_d;
    logic                gate_q, gate_d;
    logic                strobe_q, strobe_d;
    logic [DEGREE_W-1:0] pattern_q [STEPS];

    logic             start;
    logic [IDX_W-1:0] start_idx;
    logic             timer_clear;
    logic             gate_end;
    logic             step_end;

    // Counter sits at 0 while idle and clears on stop, so every step begins at 0.
    assign timer_clear = (state_q == StIdle) || !run;

    step_timer #(
        .STEP_CLKS (STEP_CLKS),
        .GATE_CLKS (GATE_CLKS)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .gate_end (gate_end),
        .step_end (step_end)
    );

    // Pattern storage; a same-edge step-start read sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(STEPS); i++) begin
                pattern_q[i] <= REST_DEGREE;
            end
        end else if (wr_en) begin
            pattern_q[wr_addr] <= wr_degree;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        degree_d  = degree_q;
        gate_d    = gate_q;
        strobe_d  = 1'b0;
        start     = 1'b0;
        start_idx = '0;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    start = 1'b1;
                end
            end
            StGateOn, StGateOff: begin
                if (!run) begin
                    state_d  = StIdle;
                    step_d   = '0;
                    degree_d = REST_DEGREE;
                    gate_d   = 1'b0;
                end else if (step_end) begin
                    start     = 1'b1;
                    start_idx = step_q + IDX_W'(1);
                end else if (HAS_GATE_OFF && (state_q == StGateOn) && gate_end) begin
                    state_d = StGateOff;
                    gate_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start) begin
            state_d  = StGateOn;
            step_d   = start_idx;
            degree_d = pattern_q[start_idx];
            gate_d   = (pattern_q[start_idx] != REST_DEGREE);
            strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            step_q   <= '0;
            degree_q <= REST_DEGREE;
            gate_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            degree_q <= degree_d;
            gate_q   <= gate_d;
            strobe_q <= strobe_d;
        end
    end

    assign scale_degree = degree_q;
    assign gate         = gate_q;
    assign step         = step_q;
    assign step_strobe  = strobe_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: a time-based model (cycles since start,
// divided into steps) checks two instances every cycle, one with a gap after the
// gate and one legato, under directed scenarios and random stimulus.
module tb_step_sequencer;

    localparam int unsigned N  = 4;
    localparam int unsigned S  = 8;
    localparam int unsigned G  = 6;
    localparam int unsigned GL = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_degree;

    logic [3:0] deg_a, deg_b;
    logic       gate_a, gate_b;
    logic [1:0] step_a, step_b;
    logic       strobe_a, strobe_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: active flag, cycles since start, latched degree, pattern copy.
    bit m_active = 1'b0;
    int m_t      = 0;
    int m_deg    = 0;
    int m_pat [N];

    always #5 clk = ~clk;

    step_sequencer #(.STEPS(N), .STEP_CLKS(S), .GATE_CLKS(G)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_degree    (wr_degree),
        .scale_degree (deg_a),
        .gate         (gate_a),
        .step         (step_a),
        .step_strobe  (strobe_a)
    );

    step_sequencer #(.STEPS(N), .STEP_CLKS(S), .GATE_CLKS(GL)) dut_leg (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_degree    (wr_degree),
        .scale_degree (deg_b),
        .gate         (gate_b),
        .step         (step_b),
        .step_strobe  (strobe_b)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int e_step();
        return m_active ? (m_t / S) % N : 0;
    endfunction

    function automatic int e_phase();
        return m_t % S;
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        int ph;
        int ed;
        @(posedge clk);
        if (rst) begin
            m_active = 1'b0;
            m_t      = 0;
            m_deg    = 0;
            for (int i = 0; i < N; i++) m_pat[i] = 0;
        end else begin
            if (m_active && !run) begin
                m_active = 1'b0;
                m_t      = 0;
            end else if (m_active) begin
                m_t++;
                if (m_t % S == 0) m_deg = m_pat[(m_t / S) % N];
            end else if (run) begin
                m_active = 1'b1;
                m_t      = 0;
                m_deg    = m_pat[0];
            end
            if (wr_en) m_pat[wr_addr] = int'(wr_degree);
        end
        #1;
        ph = e_phase();
        ed = m_active ? m_deg : 0;
        check("step", step_a, e_step());
        check("degree", deg_a, ed);
        check("strobe", strobe_a, (m_active && ph == 0) ? 1 : 0);
        check("gate", gate_a, (ed != 0 && ph < G) ? 1 : 0);
        check("leg_step", step_b, e_step());
        check("leg_degree", deg_b, ed);
        check("leg_strobe", strobe_b, (m_active && ph == 0) ? 1 : 0);
        check("leg_gate", gate_b, (ed != 0 && ph < GL) ? 1 : 0);
    endtask

    task automatic write(input int addr, input int d);
        wr_en     = 1'b1;
        wr_addr   = 2'(addr);
        wr_degree = 4'(d);
        tick();
        wr_en = 1'b0;
    endtask

    int pat0 [N] = '{3, 0, 5, 7};
    int gate_cnt;

    initial begin
        rst = 1'b1; run = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_degree = '0;
        for (int i = 0; i < N; i++) m_pat[i] = 0;

        // Reset and idle
        tick(); tick();
        rst = 1'b0;
        repeat (20) tick();
        check("idle_gate", gate_a, 0);
        check("idle_degree", deg_a, 0);
        check("idle_step", step_a, 0);
        check("idle_strobe", strobe_a, 0);

        // Basic loop {3,0,5,7}
        for (int i = 0; i < N; i++) write(i, pat0[i]);
        run = 1'b1;
        tick();
        check("s0_degree", deg_a, 3);
        check("s0_strobe", strobe_a, 1);
        check("s0_gate", gate_a, 1);
        repeat (5) tick();
        check("s0_gate_p5", gate_a, 1);
        tick();
        check("s0_gate_p6", gate_a, 0);
        check("s0_degree_p6", deg_a, 3);
        tick();
        check("s0_strobe_p7", strobe_a, 0);
        tick();
        check("s1_step", step_a, 1);
        check("s1_degree", deg_a, 0);
        check("s1_gate", gate_a, 0);
        check("s1_strobe", strobe_a, 1);
        repeat (8) tick();
        check("s2_degree", deg_a, 5);

        // Mid-step write to the playing step
        repeat (2) tick();
        write(2, 9);
        check("midwrite_held", deg_a, 5);
        repeat (5) tick();
        check("s3_step", step_a, 3);
        check("s3_degree", deg_a, 7);
        repeat (8) tick();
        check("wrap_step", step_a, 0);
        check("wrap_strobe", strobe_a, 1);

        // Write colliding with the step-1 start read
        repeat (7) tick();
        write(1, 4);
        check("collide_step", step_a, 1);
        check("collide_degree", deg_a, 0);
        check("collide_gate", gate_a, 0);
        repeat (8) tick();
        check("s2_new_degree", deg_a, 9);
        repeat (24) tick();
        check("s1_new_degree", deg_a, 4);
        check("s1_new_gate", gate_a, 1);

        // Stop in cycle 3 of step 2, then restart
        repeat (11) tick();
        run = 1'b0;
        tick();
        check("stop_gate", gate_a, 0);
        check("stop_step", step_a, 0);
        check("stop_strobe", strobe_a, 0);
        repeat (3) tick();
        run = 1'b1;
        tick();
        check("restart_step", step_a, 0);
        check("restart_strobe", strobe_a, 1);
        check("restart_degree", deg_a, 3);

        // Legato pattern {2,2,2,2}
        run = 1'b0;
        tick();
        for (int i = 0; i < N; i++) write(i, 2);
        run = 1'b1;
        tick();
        gate_cnt = 0;
        repeat (40) begin
            tick();
            if (gate_b) gate_cnt++;
        end
        check("legato_gate_cycles", gate_cnt, 40);

        // Reset mid-step while running
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_gate", gate_b, 0);
        check("rst_step", step_b, 0);
        rst = 1'b0;
        tick();
        check("rst_restart_strobe", strobe_b, 1);
        check("rst_restart_degree", deg_b, 0);
        gate_cnt = 0;
        repeat (32) begin
            tick();
            if (gate_b || gate_a) gate_cnt++;
        end
        check("rst_rest_gate_cycles", gate_cnt, 0);

        // Random stimulus
        for (int c = 0; c < 800; c++) begin
            rst   = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 29) == 0) run = ~run;
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = 2'($urandom_range(0, N - 1));
            wr_degree = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0; wr_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
